// File: rtl/apb_gpio_debounce_if.sv
// Purpose: pad-side and configuration signal bundle for apb_gpio_debounce.
//   master : drives gpio_in / cfg_* and observes gpio_out / evt_*
//   slave  : the debounce block itself
// Ports carried:
//   gpio_in       raw pad inputs (asynchronous to HCLK)
//   cfg_en        per-pin filter enable (0 = synchroniser-only bypass)
//   cfg_prescale  tick every cfg_prescale+1 HCLK cycles
//   cfg_threshold extra ticks a new level must persist
//   gpio_out      filtered level
//   evt_rise      filtered rising-edge pulse  (GPIO_DEBOUNCE_EVT_EN builds only)
//   evt_fall      filtered falling-edge pulse (GPIO_DEBOUNCE_EVT_EN builds only)
interface apb_gpio_debounce_if #(
  parameter int unsigned NUM_GPIO    = 32,
  parameter int unsigned CNT_WIDTH   = 8,
  parameter int unsigned PRESC_WIDTH = 16
);
  logic [NUM_GPIO-1:0]    gpio_in;
  logic [NUM_GPIO-1:0]    cfg_en;
  logic [PRESC_WIDTH-1:0] cfg_prescale;
  logic [CNT_WIDTH-1:0]   cfg_threshold;
  logic [NUM_GPIO-1:0]    gpio_out;
  logic [NUM_GPIO-1:0]    evt_rise;
  logic [NUM_GPIO-1:0]    evt_fall;

  modport master (
    output gpio_in, cfg_en, cfg_prescale, cfg_threshold,
    input  gpio_out, evt_rise, evt_fall
  );

  modport slave (
    input  gpio_in, cfg_en, cfg_prescale, cfg_threshold,
    output gpio_out, evt_rise, evt_fall
  );
endinterface

// File: rtl/apb_gpio_debounce.sv
// Purpose: per-pin glitch filter for the GPIO pad inputs. Each pin passes a
//   2-flop synchroniser and, when enabled, a saturating stability counter
//   advanced by a shared prescaler tick. gpio_out only changes once a new
//   level has been held for cfg_threshold+1 ticks.
// Ports:
//   HCLK     system clock (posedge)
//   HRESETn  asynchronous active-low reset
//   bus      apb_gpio_debounce_if.slave (gpio_in, cfg_*, gpio_out, evt_*)
// Build option: define GPIO_DEBOUNCE_EVT_EN to instantiate the registered
//   evt_rise/evt_fall pulse outputs; otherwise they are tied to 0.
module apb_gpio_debounce #(
  parameter int unsigned NUM_GPIO    = 32,
  parameter int unsigned CNT_WIDTH   = 8,
  parameter int unsigned PRESC_WIDTH = 16
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  apb_gpio_debounce_if.slave      bus
);

  logic [NUM_GPIO-1:0]    r_sync0;
  logic [NUM_GPIO-1:0]    r_sync1;
  logic [NUM_GPIO-1:0]    r_stable;
  logic [CNT_WIDTH-1:0]   r_cnt [NUM_GPIO];
  logic [PRESC_WIDTH-1:0] r_presc_cnt;

  logic                   w_tick;
  logic [PRESC_WIDTH-1:0] w_presc_nxt;
  logic [NUM_GPIO-1:0]    w_stable_nxt;
  logic [CNT_WIDTH-1:0]   w_cnt_nxt [NUM_GPIO];

  // Prescaler: >= compare makes a runtime decrease of cfg_prescale tick at once
  // instead of wrapping the counter.
  always_comb begin
    w_tick      = (r_presc_cnt >= bus.cfg_prescale);
    w_presc_nxt = w_tick ? '0 : r_presc_cnt + PRESC_WIDTH'(1);
  end

  // Per-pin qualification; counter never passes cfg_threshold because it is
  // only incremented while below it.
  always_comb begin
    w_stable_nxt = r_stable;
    for (int i = 0; i < int'(NUM_GPIO); i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (!bus.cfg_en[i]) begin
        w_stable_nxt[i] = r_sync1[i];
        w_cnt_nxt[i]    = '0;
      end else if (r_sync1[i] == r_stable[i]) begin
        w_cnt_nxt[i]    = '0;
      end else if (w_tick) begin
        if (r_cnt[i] >= bus.cfg_threshold) begin
          w_stable_nxt[i] = r_sync1[i];
          w_cnt_nxt[i]    = '0;
        end else begin
          w_cnt_nxt[i]    = r_cnt[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // State registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_sync0     <= '0;
      r_sync1     <= '0;
      r_stable    <= '0;
      r_presc_cnt <= '0;
      for (int i = 0; i < int'(NUM_GPIO); i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync0     <= bus.gpio_in;
      r_sync1     <= r_sync0;
      r_stable    <= w_stable_nxt;
      r_presc_cnt <= w_presc_nxt;
      for (int i = 0; i < int'(NUM_GPIO); i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign bus.gpio_out = r_stable;

`ifdef GPIO_DEBOUNCE_EVT_EN
  logic [NUM_GPIO-1:0] r_evt_rise;
  logic [NUM_GPIO-1:0] r_evt_fall;

  // Edge pulses registered alongside r_stable so they coincide with gpio_out.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_evt_rise <= '0;
      r_evt_fall <= '0;
    end else begin
      r_evt_rise <= w_stable_nxt & ~r_stable;
      r_evt_fall <= ~w_stable_nxt & r_stable;
    end
  end

  assign bus.evt_rise = r_evt_rise;
  assign bus.evt_fall = r_evt_fall;
`else
  assign bus.evt_rise = '0;
  assign bus.evt_fall = '0;
`endif

endmodule
